// File: rtl/me_mv_engine.sv
// Motion-estimation block sequencer: fetch, SAD search, MV emit.
// Optional zero-MV bias selected by defining ME_ZERO_BIAS_EN.
module me_mv_engine #(
  parameter int SAD_W           = 14,
  parameter int SR_W            = 16,
  parameter int SR_H            = 16,
  parameter int MV_W            = 6,
  parameter int BLOCKS_PER_LINE = 482,
  parameter int LINES_PER_FRAME = 270,
  parameter int CUR_BEATS       = 16,
  parameter int ZERO_BIAS       = 64
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  output logic             need_cur_o,
  input  logic             cur_valid_i,
  output logic             need_ref_o,
  input  logic             sad_valid_i,
  input  logic [SAD_W-1:0] sad_i,
  output logic             mv_valid_o,
  input  logic             mv_ready_i,
  output logic [MV_W-1:0]  mv_x_o,
  output logic [MV_W-1:0]  mv_y_o,
  output logic [SAD_W-1:0] mv_sad_o,
  output logic [15:0]      blk_x_o,
  output logic [15:0]      blk_y_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             sad_drop_o
);

  localparam int BW = $clog2(CUR_BEATS + 1);
  localparam int XW = (SR_W > 1) ? $clog2(SR_W) : 1;
  localparam int YW = (SR_H > 1) ? $clog2(SR_H) : 1;

`ifdef ME_ZERO_BIAS_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif

  localparam logic [SAD_W-1:0] BIAS = SAD_W'(ZERO_BIAS);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEARCH,
    EMIT
  } state_t;

  state_t state;

  logic [BW-1:0]    beat_cnt;
  logic [XW-1:0]    cx;
  logic [YW-1:0]    cy;
  logic [SAD_W-1:0] best_cmp;
  logic [SAD_W-1:0] best_sad;
  logic [MV_W-1:0]  best_x;
  logic [MV_W-1:0]  best_y;

  logic             zero_cand;
  logic [SAD_W-1:0] cmp_val;
  logic             better;
  logic             last_cand;
  logic             last_blk;
  logic             last_beat;
  logic [MV_W-1:0]  cand_x;
  logic [MV_W-1:0]  cand_y;

  assign zero_cand = (cx == XW'(SR_W / 2)) && (cy == YW'(SR_H / 2));
  assign cand_x    = MV_W'(cx) - MV_W'(SR_W / 2);
  assign cand_y    = MV_W'(cy) - MV_W'(SR_H / 2);
  assign last_cand = (cx == XW'(SR_W - 1)) && (cy == YW'(SR_H - 1));
  assign last_beat = (beat_cnt == BW'(CUR_BEATS - 1));
  assign last_blk  = (blk_x_o == 16'(BLOCKS_PER_LINE - 1)) &&
                     (blk_y_o == 16'(LINES_PER_FRAME - 1));

  // Biased value only steers selection; the stored SAD stays raw.
  always_comb begin
    cmp_val = sad_i;
    if (BIAS_EN && zero_cand) begin
      cmp_val = (sad_i > BIAS) ? (sad_i - BIAS) : '0;
    end
  end

  assign better = sad_valid_i && (cmp_val < best_cmp);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      cx           <= '0;
      cy           <= '0;
      best_cmp     <= '1;
      best_sad     <= '0;
      best_x       <= '0;
      best_y       <= '0;
      need_cur_o   <= 1'b0;
      need_ref_o   <= 1'b0;
      mv_valid_o   <= 1'b0;
      mv_x_o       <= '0;
      mv_y_o       <= '0;
      mv_sad_o     <= '0;
      blk_x_o      <= '0;
      blk_y_o      <= '0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      sad_drop_o   <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      if (sad_valid_i && state != SEARCH) begin
        sad_drop_o <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (start_i) begin
            state      <= LOAD;
            blk_x_o    <= '0;
            blk_y_o    <= '0;
            sad_drop_o <= sad_valid_i;
            need_cur_o <= 1'b1;
            need_ref_o <= 1'b1;
            busy_o     <= 1'b1;
            beat_cnt   <= '0;
          end
        end
        LOAD: begin
          best_cmp <= '1;
          cx       <= '0;
          cy       <= '0;
          if (cur_valid_i) begin
            beat_cnt <= beat_cnt + BW'(1);
            if (last_beat) begin
              state      <= SEARCH;
              need_cur_o <= 1'b0;
            end
          end
        end
        SEARCH: begin
          if (sad_valid_i) begin
            if (better) begin
              best_cmp <= cmp_val;
              best_sad <= sad_i;
              best_x   <= cand_x;
              best_y   <= cand_y;
            end
            if (cx == XW'(SR_W - 1)) begin
              cx <= '0;
              cy <= cy + YW'(1);
            end else begin
              cx <= cx + XW'(1);
            end
            if (last_cand) begin
              state      <= EMIT;
              need_ref_o <= 1'b0;
              mv_valid_o <= 1'b1;
              mv_x_o     <= better ? cand_x : best_x;
              mv_y_o     <= better ? cand_y : best_y;
              mv_sad_o   <= better ? sad_i : best_sad;
            end
          end
        end
        EMIT: begin
          if (mv_ready_i) begin
            mv_valid_o <= 1'b0;
            if (last_blk) begin
              state        <= IDLE;
              blk_x_o      <= '0;
              blk_y_o      <= '0;
              busy_o       <= 1'b0;
              frame_done_o <= 1'b1;
            end else begin
              state      <= LOAD;
              need_cur_o <= 1'b1;
              need_ref_o <= 1'b1;
              beat_cnt   <= '0;
              if (blk_x_o == 16'(BLOCKS_PER_LINE - 1)) begin
                blk_x_o <= '0;
                blk_y_o <= blk_y_o + 16'd1;
              end else begin
                blk_x_o <= blk_x_o + 16'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_me_mv_engine.sv
// Scoreboard bench for me_mv_engine: 4x4 window, 3x2-block frame.
// Expected MVs come from an independent min-search model.
module tb_me_mv_engine;

  localparam int SAD_W = 14;
  localparam int MV_W  = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             need_cur;
  logic             cur_valid;
  logic             need_ref;
  logic             sad_valid;
  logic [SAD_W-1:0] sad;
  logic             mv_valid;
  logic             mv_ready;
  logic [MV_W-1:0]  mv_x;
  logic [MV_W-1:0]  mv_y;
  logic [SAD_W-1:0] mv_sad;
  logic [15:0]      blk_x;
  logic [15:0]      blk_y;
  logic             busy;
  logic             frame_done;
  logic             sad_drop;

  always #5 clk = ~clk;

  me_mv_engine #(
    .SAD_W(SAD_W),
    .SR_W(4),
    .SR_H(4),
    .MV_W(MV_W),
    .BLOCKS_PER_LINE(3),
    .LINES_PER_FRAME(2),
    .CUR_BEATS(16),
    .ZERO_BIAS(64)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .start_i(start),
    .need_cur_o(need_cur),
    .cur_valid_i(cur_valid),
    .need_ref_o(need_ref),
    .sad_valid_i(sad_valid),
    .sad_i(sad),
    .mv_valid_o(mv_valid),
    .mv_ready_i(mv_ready),
    .mv_x_o(mv_x),
    .mv_y_o(mv_y),
    .mv_sad_o(mv_sad),
    .blk_x_o(blk_x),
    .blk_y_o(blk_y),
    .busy_o(busy),
    .frame_done_o(frame_done),
    .sad_drop_o(sad_drop)
  );

  typedef struct {
    logic [MV_W-1:0]  x;
    logic [MV_W-1:0]  y;
    logic [SAD_W-1:0] s;
    logic [15:0]      bx;
    logic [15:0]      by;
  } exp_t;

  exp_t q[$];
  logic [SAD_W-1:0] sads[16];
  int errs   = 0;
  int checks = 0;
  int bx     = 0;
  int by     = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model();
    int   best;
    int   bi;
    int   c;
    exp_t e;
    best = 32'h7fff_ffff;
    bi   = 0;
    for (int i = 0; i < 16; i++) begin
      c = int'(sads[i]);
`ifdef ME_ZERO_BIAS_EN
      if (i == 10) c = (c > 64) ? c - 64 : 0;
`endif
      if (c < best) begin
        best = c;
        bi   = i;
      end
    end
    e.x  = MV_W'((bi % 4) - 2);
    e.y  = MV_W'((bi / 4) - 2);
    e.s  = sads[bi];
    e.bx = 16'(bx);
    e.by = 16'(by);
    q.push_back(e);
  endtask

  task automatic run_block(input int hold, input bit drop);
    int   n;
    int   t;
    exp_t e;
    n = 0;
    t = 0;
    cur_valid = 1'b1;
    while (!need_cur && t < 50) begin
      @(negedge clk);
      t++;
    end
    while (need_cur && t < 100) begin
      n++;
      @(negedge clk);
      t++;
    end
    cur_valid = 1'b0;
    check("cur_beats", 32'(n), 32'd16);
    check("ref_in_search", {31'b0, need_ref}, 32'd1);
    model();
    for (int i = 0; i < 16; i++) begin
      sad_valid = 1'b1;
      sad       = sads[i];
      if (i == 15) check("early_valid", {31'b0, mv_valid}, 32'd0);
      @(negedge clk);
    end
    sad_valid = 1'b0;
    check("mv_latency", {31'b0, mv_valid}, 32'd1);
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", {31'b0, mv_valid}, 32'd1);
      check("hold_x", {26'b0, mv_x}, {26'b0, q[0].x});
      check("hold_sad", {18'b0, mv_sad}, {18'b0, q[0].s});
      sad_valid = drop && (h == 3);
      @(negedge clk);
    end
    sad_valid = 1'b0;
    if (drop) check("sad_drop_set", {31'b0, sad_drop}, 32'd1);
    t = 0;
    while (!mv_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("mv_valid_wait", {31'b0, mv_valid}, 32'd1);
    mv_ready = 1'b1;
    if (q.size() != 0) begin
      e = q.pop_front();
      check("mv_x", {26'b0, mv_x}, {26'b0, e.x});
      check("mv_y", {26'b0, mv_y}, {26'b0, e.y});
      check("mv_sad", {18'b0, mv_sad}, {18'b0, e.s});
      check("blk_x", {16'b0, blk_x}, {16'b0, e.bx});
      check("blk_y", {16'b0, blk_y}, {16'b0, e.by});
    end
    @(negedge clk);
    mv_ready = 1'b0;
    check("valid_drop", {31'b0, mv_valid}, 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    cur_valid = 1'b0;
    sad_valid = 1'b0;
    sad       = '0;
    mv_ready  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_need_cur", {31'b0, need_cur}, 32'd0);
    check("rst_need_ref", {31'b0, need_ref}, 32'd0);
    check("rst_valid", {31'b0, mv_valid}, 32'd0);
    check("rst_drop", {31'b0, sad_drop}, 32'd0);
    check("rst_blk", {blk_y, blk_x}, 32'd0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_load", {31'b0, busy}, 32'd1);
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 16; i++) begin
        case (b)
          0:       sads[i] = (i == 9) ? 14'd5 : 14'd100;
          1:       sads[i] = 14'd200;
          3:       sads[i] = (i == 0) ? 14'd60 : (i == 10) ? 14'd100 : 14'd1000;
          default: sads[i] = SAD_W'($urandom_range(16000, 0));
        endcase
      end
      run_block((b == 2) ? 10 : 0, b == 2);
      check("frame_done", {31'b0, frame_done}, {31'b0, b == 5});
      if (bx == 2) begin
        bx = 0;
        by++;
      end else begin
        bx++;
      end
    end
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("idle_blk", {blk_y, blk_x}, 32'd0);
    check("drop_sticky", {31'b0, sad_drop}, 32'd1);
    @(negedge clk);
    check("done_pulse", {31'b0, frame_done}, 32'd0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("drop_clear", {31'b0, sad_drop}, 32'd0);
    cur_valid = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_need_cur", {31'b0, need_cur}, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    cur_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_done", {31'b0, frame_done}, 32'd0);
    end
    check("post_rst_valid", {31'b0, mv_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/me_mv_engine.md
Name: me_mv_engine

Overview:
- Parametrised block-level sequencer for the motion-estimation datapath.
- Paces current-block fetches, then consumes the per-candidate SAD stream from the AD array over a configurable search window.
- Tracks the minimum SAD and emits one motion vector per block over a valid/ready handshake.
- Replaces the fixed free-running line/read counters at ME top level with a frame-aware FSM: generalised block count, search window and beat count.

Parameters:
- SAD_W, 14, SAD width in bits (8x8 block of 8-bit pixels: max 16320).
- SR_W, 16, horizontal candidate count per block (even, >=2).
- SR_H, 16, vertical candidate count per block (even, >=2).
- MV_W, 6, signed MV component width; must hold -SR/2..SR/2-1.
- BLOCKS_PER_LINE, 482, blocks per block-row.
- LINES_PER_FRAME, 270, block-rows per frame.
- CUR_BEATS, 16, cur_in beats per current block.
- ZERO_BIAS, 64, SAD bias for the zero MV (used only with the optional feature).

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset
- start_i  in  1  frame start pulse; ignored unless IDLE
- need_cur_o  out  1  current-block beat request
- cur_valid_i  in  1  cur beat delivered; a beat counts when need_cur_o && cur_valid_i
- need_ref_o  out  1  reference stream enable
- sad_valid_i  in  1  SAD beat valid
- sad_i  in  SAD_W  candidate SAD
- mv_valid_o  out  1  result valid
- mv_ready_i  in  1  result accepted
- mv_x_o  out  MV_W  signed MV x
- mv_y_o  out  MV_W  signed MV y
- mv_sad_o  out  SAD_W  SAD of chosen candidate (unbiased)
- blk_x_o  out  16  current block column
- blk_y_o  out  16  current block row
- busy_o  out  1  high in any state except IDLE
- frame_done_o  out  1  one-cycle pulse after the last block's MV handshake
- sad_drop_o  out  1  sticky: SAD arrived outside SEARCH

Interface rule: one clock, clk_i. Reset rst_n_i is asynchronous and active-low.

Behaviour:
- Reset: all outputs and counters 0; FSM in IDLE; best SAD register all-ones.
- FSM states: IDLE, LOAD, SEARCH, EMIT.
- IDLE:
  - start_i=1 -> LOAD next cycle; blk_x/blk_y cleared; sad_drop cleared.
- LOAD:
  - need_cur_o=1 and need_ref_o=1.
  - Beat counter increments on each accepted beat.
  - On the CUR_BEATS-th beat -> SEARCH next cycle; need_cur_o drops in that same next cycle.
  - Best SAD reset to all-ones; candidate counters cx and cy reset to 0.
- SEARCH:
  - need_ref_o=1; need_cur_o=0.
  - Each sad_valid_i beat is candidate (cx, cy) in raster order, cx fastest.
  - Update best when sad_i < best (strict less-than). Ties keep the earlier candidate.
  - Stored MV: x = cx - SR_W/2, y = cy - SR_H/2 (two's complement, MV_W bits).
  - The SR_W*SR_H-th beat is compared in that cycle -> EMIT next cycle, with mv_valid_o=1 and final values on the outputs.
- EMIT:
  - mv_valid_o, mv_* and blk_* are held stable until mv_ready_i=1.
  - On handshake:
    - If the block is not last: blk_x++. When blk_x wraps from BLOCKS_PER_LINE-1 to 0, blk_y++. -> LOAD.
    - If the block is last (blk_x=BLOCKS_PER_LINE-1, blk_y=LINES_PER_FRAME-1): frame_done_o pulses one cycle -> IDLE; blk_* return to 0.
  - need_ref_o=0 in EMIT and IDLE.
- sad_valid_i outside SEARCH: beat is discarded, sad_drop_o set (sticky until next accepted start_i).
- cur_valid_i outside LOAD is ignored.
- start_i while busy is ignored.
- Reset asserted mid-frame: immediate return to reset state, no frame_done_o, pending MV lost.
- Latency: last SAD beat -> mv_valid_o exactly 1 cycle.

Optional Feature:
- Macro: ME_ZERO_BIAS_EN.
- Defined: for the zero-MV candidate (cx=SR_W/2, cy=SR_H/2), the comparison value is max(sad_i - ZERO_BIAS, 0). mv_sad_o still reports the unbiased sad_i.
- Undefined: no bias; ZERO_BIAS unused; pure strict-minimum selection.

Test Plan:
Tests use SR_W=SR_H=4, CUR_BEATS=16, BLOCKS_PER_LINE=3, LINES_PER_FRAME=2, macro undefined unless stated.
- Reset then start_i, cur_valid_i held high -> need_cur_o high exactly 16 cycles; SEARCH entered on cycle 17.
- 16 SADs all 100 except index 9 = 5 -> mv=(-1,0), mv_sad=5, mv_valid_o one cycle after the 16th beat.
- All SADs equal 200 -> first candidate wins: mv=(-2,-2), mv_sad=200.
- mv_ready_i held low 10 cycles in EMIT -> outputs stable; extra sad_valid_i pulse sets sad_drop_o=1, result unchanged.
- Full frame of 6 blocks with immediate ready -> blk sequence (0,0)(1,0)(2,0)(0,1)(1,1)(2,1); frame_done_o single pulse; FSM in IDLE.
- ME_ZERO_BIAS_EN, ZERO_BIAS=64: zero-MV SAD=100, index 0 SAD=60 -> mv=(0,0), mv_sad=100. Same stimulus without macro -> mv=(-2,-2), mv_sad=60.
